// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg: segment pattern constants, FSM state type and pattern-to-digit lookup
package seven_segment_pkg;
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h1F;
    localparam logic [6:0] SEG_C     = 7'h4E;
    localparam logic [6:0] SEG_D     = 7'h3D;
    localparam logic [6:0] SEG_E     = 7'h4F;
    localparam logic [6:0] SEG_F     = 7'h47;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {ST_SETTLE, ST_LOCKED} state_e;

    // Returns {legal, digit}; any pattern outside the table (blank included) is illegal.
    function automatic logic [4:0] seg_to_digit(input logic [6:0] seg);
        case (seg)
            SEG_0:   return 5'h10;
            SEG_1:   return 5'h11;
            SEG_2:   return 5'h12;
            SEG_3:   return 5'h13;
            SEG_4:   return 5'h14;
            SEG_5:   return 5'h15;
            SEG_6:   return 5'h16;
            SEG_7:   return 5'h17;
            SEG_8:   return 5'h18;
            SEG_9:   return 5'h19;
            SEG_A:   return 5'h1A;
            SEG_B:   return 5'h1B;
            SEG_C:   return 5'h1C;
            SEG_D:   return 5'h1D;
            SEG_E:   return 5'h1E;
            SEG_F:   return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction
endpackage

// File: rtl/seg_sync.sv
// seg_sync: 2-flop synchronizer for the 7 asynchronous segment lines
module seg_sync (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [6:0] i_d,
    output logic [6:0] o_q
);
    logic [6:0] meta_q;
    logic [6:0] sync_q;

    // Two-stage capture chain to resolve metastability
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;
endmodule

// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder: debounced 7-segment pattern to hex digit decoder.
// Build option SEG_ACTIVE_LOW_EN inverts the segment lines (common-anode displays).
module seven_segment_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_segment_a,
    input  logic       i_segment_b,
    input  logic       i_segment_c,
    input  logic       i_segment_d,
    input  logic       i_segment_e,
    input  logic       i_segment_f,
    input  logic       i_segment_g,
    output logic [3:0] o_binary_num,
    output logic       o_valid,
    output logic       o_error,
    output logic       o_update
);
    import seven_segment_pkg::*;

    logic [6:0] seg_raw;
    logic [6:0] seg_in;
    logic [6:0] seg_s;
    logic [6:0] prev_q;
    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] num_q, num_d;
    logic       valid_q, valid_d;
    logic       error_q, error_d;
    logic       update_q, update_d;
    logic [4:0] dec;
    logic       stable;
    logic       lock;

    assign seg_raw = {i_segment_a, i_segment_b, i_segment_c, i_segment_d,
                      i_segment_e, i_segment_f, i_segment_g};

`ifdef SEG_ACTIVE_LOW_EN
    assign seg_in = ~seg_raw;
`else
    assign seg_in = seg_raw;
`endif

    seg_sync u_sync (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (seg_in),
        .o_q    (seg_s)
    );

    // Lock fires on the edge where the stability count steps up to STABLE_CYCLES,
    // which gives STABLE_CYCLES+3 edges from an input change to new outputs.
    always_comb begin
        dec    = seg_to_digit(seg_s);
        stable = (seg_s == prev_q);
        lock   = (state_q == ST_SETTLE) && stable && (cnt_q == 8'(STABLE_CYCLES - 1));
    end

    // Next-state, stability counter and output update logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        num_d    = num_q;
        valid_d  = valid_q;
        error_d  = error_q;
        update_d = 1'b0;
        if (!stable) begin
            state_d = ST_SETTLE;
            cnt_d   = 8'd0;
        end else if (lock) begin
            state_d  = ST_LOCKED;
            cnt_d    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            num_d    = dec[4] ? dec[3:0] : num_q;
            valid_d  = dec[4];
            error_d  = !dec[4];
            update_d = (num_d != num_q) || (valid_d != valid_q);
        end else if (state_q == ST_SETTLE) begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_q   <= '0;
            state_q  <= ST_SETTLE;
            cnt_q    <= '0;
            num_q    <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            update_q <= 1'b0;
        end else begin
            prev_q   <= seg_s;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
            update_q <= update_d;
        end
    end

    assign o_binary_num = num_q;
    assign o_valid      = valid_q;
    assign o_error      = error_q;
    assign o_update     = update_q;
endmodule

// File: tb/tb_seven_segment_decoder.sv
// tb_seven_segment_decoder: directed and randomized checks against a run-length reference model
module tb_seven_segment_decoder;
    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] drv = 7'h00;
    logic [3:0] o_binary_num;
    logic       o_valid, o_error, o_update;

    int errors = 0;
    int checks = 0;

    logic [6:0] tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Model: a raw pattern held for S+1 sampled edges gets decoded two edges later.
    logic [6:0] cur = 7'h00;
    logic [6:0] m_prev;
    int         m_run;
    logic       m_d1v, m_d2v;
    logic [6:0] m_d1p, m_d2p;
    int exp_num, exp_valid, exp_err, exp_upd;
    int upd_cnt;

    seven_segment_decoder #(.STABLE_CYCLES(S)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_segment_a (drv[6]),
        .i_segment_b (drv[5]),
        .i_segment_c (drv[4]),
        .i_segment_d (drv[3]),
        .i_segment_e (drv[2]),
        .i_segment_f (drv[1]),
        .i_segment_g (drv[0]),
        .o_binary_num(o_binary_num),
        .o_valid     (o_valid),
        .o_error     (o_error),
        .o_update    (o_update)
    );

    always #5 clk = ~clk;

    function automatic int ref_digit(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (tbl[i] == p) return i;
        return -1;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_pat(input logic [6:0] p);
        cur = p;
`ifdef SEG_ACTIVE_LOW_EN
        drv = ~p;
`else
        drv = p;
`endif
    endtask

    task automatic model_reset();
        m_prev = 7'h00; m_run = 0;
        m_d1v = 1'b0; m_d2v = 1'b0; m_d1p = 7'h00; m_d2p = 7'h00;
        exp_num = 0; exp_valid = 0; exp_err = 0; exp_upd = 0;
    endtask

    task automatic model_edge(input logic [6:0] v);
        int d, nn, nv;
        exp_upd = 0;
        if (m_d2v) begin
            d  = ref_digit(m_d2p);
            nv = (d >= 0) ? 1 : 0;
            nn = nv ? d : exp_num;
            exp_upd = (nn != exp_num || nv != exp_valid) ? 1 : 0;
            exp_num = nn; exp_valid = nv; exp_err = 1 - nv;
        end
        m_d2v = m_d1v; m_d2p = m_d1p;
        m_run = (v == m_prev) ? m_run + 1 : 1;
        m_prev = v;
        m_d1v = (m_run == S + 1);
        m_d1p = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge(cur);
        check("num",    int'(o_binary_num), exp_num);
        check("valid",  int'(o_valid),      exp_valid);
        check("error",  int'(o_error),      exp_err);
        check("update", int'(o_update),     exp_upd);
        if (o_update) upd_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_num",    int'(o_binary_num), 0);
        check("rst_valid",  int'(o_valid),      0);
        check("rst_error",  int'(o_error),      0);
        check("rst_update", int'(o_update),     0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        // Reset with digit 0 held, lock 7 edges after release
        set_pat(7'h7E);
        @(posedge clk); #1;
        do_reset();
        ticks(6);
        check("d0_early_valid", int'(o_valid), 0);
        tick();
        check("d0_num",    int'(o_binary_num), 0);
        check("d0_valid",  int'(o_valid),      1);
        check("d0_update", int'(o_update),     1);
        tick();
        check("d0_pulse_end", int'(o_update), 0);
        // Digit 5 held 20 cycles: one pulse, value appears on edge 7
        set_pat(7'h5B);
        upd_cnt = 0;
        ticks(6);
        check("d5_early_num", int'(o_binary_num), 0);
        tick();
        check("d5_num", int'(o_binary_num), 5);
        ticks(13);
        check("d5_pulses", upd_cnt, 1);
        // Lock at 1, short glitch to 8, back to 1: nothing observable
        set_pat(7'h30);
        ticks(12);
        check("d1_num", int'(o_binary_num), 1);
        upd_cnt = 0;
        set_pat(7'h7F);
        ticks(2);
        set_pat(7'h30);
        ticks(14);
        check("glitch_pulses", upd_cnt, 0);
        check("glitch_num", int'(o_binary_num), 1);
        // Glitch exactly STABLE_CYCLES long is still rejected
        set_pat(7'h7F);
        ticks(S);
        set_pat(7'h30);
        ticks(14);
        check("glitch_s_num", int'(o_binary_num), 1);
        // Digit 5 then illegal 0x01: error, value held, one pulse
        set_pat(7'h5B);
        ticks(12);
        upd_cnt = 0;
        set_pat(7'h01);
        ticks(14);
        check("ill_pulses", upd_cnt, 1);
        check("ill_error",  int'(o_error),      1);
        check("ill_valid",  int'(o_valid),      0);
        check("ill_num",    int'(o_binary_num), 5);
        // Blank pattern is illegal too
        set_pat(7'h00);
        ticks(12);
        check("blank_error", int'(o_error), 1);
        // Reset on the 3rd stable cycle of digit 3: full window needed afterwards
        set_pat(7'h79);
        ticks(5);
        do_reset();
        ticks(6);
        check("d3_early_num", int'(o_binary_num), 0);
        tick();
        check("d3_num",   int'(o_binary_num), 3);
        check("d3_valid", int'(o_valid),      1);
        // Randomized runs of legal and arbitrary patterns
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) set_pat(7'($urandom_range(0, 127)));
            else set_pat(tbl[$urandom_range(0, 15)]);
            ticks($urandom_range(1, 12));
        end
        ticks(12);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
